// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one beat-wide memory port between ICache refills and DCache line reads/writebacks
module mem_refill_arbiter #(
  parameter int Offset_len = 6,
  parameter int BEAT_W = 32,
  localparam int LINE_W = 1 << (3 + Offset_len),
  localparam int BEATS = LINE_W / BEAT_W,
  localparam int CW = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rvalid,
  input  logic [31:0]       i_addr,
  output logic              i_rready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_rvalid,
  input  logic              d_wvalid,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_rready,
  output logic              d_wready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic [31:0]       i_refill_cnt,
  output logic [31:0]       d_refill_cnt
);
  localparam logic [2:0] IDLE = 3'd0, IRD = 3'd1, DRD = 3'd2, DWR = 3'd3, DONE = 3'd4;
  logic [2:0] state, cur;
  logic last_d;
  logic [LINE_W-1:0] line;
  logic [CW-1:0] beat_cnt, bn;
  logic d_req, gi, gd, last_beat;
  logic [31:0] gaddr;
  // round-robin grant: on contention the channel that did not win last time goes first
  always_comb begin
    d_req = d_wvalid | d_rvalid;
    gi = i_rvalid & (~d_req | last_d);
    gd = d_req & (~i_rvalid | ~last_d);
    gaddr = gi ? i_addr : d_addr;
    last_beat = beat_cnt == CW'(BEATS - 1);
    bn = beat_cnt + 1'b1;
  end
  // burst sequencer: grant, stream BEATS beats, publish line and raise ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur <= IDLE;
      last_d <= 1'b1;
      line <= '0;
      beat_cnt <= '0;
      i_rready <= 1'b1;
      d_rready <= 1'b1;
      d_wready <= 1'b1;
      i_rdata <= '0;
      d_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      i_refill_cnt <= '0;
      d_refill_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (gi | gd) begin
          state <= gi ? IRD : (d_wvalid ? DWR : DRD);
          cur <= gi ? IRD : (d_wvalid ? DWR : DRD);
          last_d <= gd;
          i_rready <= ~gi;
          d_wready <= ~(gd & d_wvalid);
          d_rready <= ~(gd & ~d_wvalid);
          mem_req <= 1'b1;
          mem_we <= gd & d_wvalid;
          mem_addr <= gaddr & ~32'((1 << Offset_len) - 1);
          line <= d_wdata;
          mem_wdata <= d_wdata[BEAT_W-1:0];
          beat_cnt <= '0;
        end
        IRD, DRD, DWR: if (mem_ack) begin
          if (state != DWR) line[BEAT_W*beat_cnt +: BEAT_W] <= mem_rdata;
          mem_wdata <= line[BEAT_W*bn +: BEAT_W];
          beat_cnt <= bn;
          mem_addr <= mem_addr + 32'd4;
          if (last_beat) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (cur == IRD) begin
            i_rdata <= line;
            i_rready <= 1'b1;
            i_refill_cnt <= i_refill_cnt + 32'd1;
          end else begin
            if (cur == DRD) d_rdata <= line;
            d_rready <= 1'b1;
            d_wready <= 1'b1;
            d_refill_cnt <= d_refill_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
